// File: rtl/mc_stat_bus_ctrl_if.sv
// Byte-wide internal bus between the uart2bus bridge and the Monte-Carlo statistics controller.
// The bridge drives the master side; the controller answers on the slave side.
interface mc_stat_bus_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] int_address;
    logic [7:0]        int_wr_data;
    logic              int_write;
    logic              int_read;
    logic              int_req;
    logic              int_gnt;
    logic [7:0]        int_rd_data;

    modport master (
        output int_address, int_wr_data, int_write, int_read, int_req,
        input  int_gnt, int_rd_data
    );

    modport slave (
        input  int_address, int_wr_data, int_write, int_read, int_req,
        output int_gnt, int_rd_data
    );
endinterface

// File: rtl/mc_stat_bus_ctrl.sv
// Register bank holding board, seed and run control for N_CH monteCarloStat engines,
// with per-channel statistics windows that snapshot coherently on a read of byte 0.
module mc_stat_bus_ctrl #(
    parameter int N_CH      = 4,
    parameter int CELLS     = 16,
    parameter int CELL_W    = 6,
    parameter int ADDR_W    = 16,
    parameter int CH_BASE   = 32,
    parameter int CH_STRIDE = 16,
    parameter int MAX_W     = 16,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    mc_stat_bus_ctrl_if.slave       bus,
    output logic [CELLS*CELL_W-1:0] board,
    output logic [7:0]              seed,
    output logic                    engine_rst,
    input  logic [N_CH*MAX_W-1:0]   max_move,
    input  logic [N_CH*CNT_W-1:0]   total_move,
    input  logic [N_CH*CNT_W-1:0]   total_trial
);

    localparam int SEED_ADDR = 16;
    localparam int CTRL_ADDR = 17;
    localparam int STAT_ADDR = 18;

    logic              gnt_q;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        seed_q, seed_d;
    logic              run_q, run_d;
    logic              clear_q, clear_d;
    logic              engine_rst_q;
    logic [CELL_W-1:0] cell_q     [CELLS];
    logic [MAX_W-1:0]  snap_max_q [N_CH];
    logic [CNT_W-1:0]  snap_tm_q  [N_CH];
    logic [CNT_W-1:0]  snap_tt_q  [N_CH];

    logic        wr_en, rd_en, cell_we, snap_en;
    logic [31:0] addr;
    logic        ch_hit;
    logic [31:0] ch_sel, ch_k;
    logic [31:0] live_max, s_max, s_tm, s_tt;
    logic [7:0]  rd_byte;

    // A read colliding with a write is dropped so the write side effects stay unambiguous.
    assign wr_en = gnt_q & bus.int_write;
    assign rd_en = gnt_q & bus.int_read & ~bus.int_write;
    assign addr  = 32'(bus.int_address);

    // NOTE: every variable assigned in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        ch_hit   = 1'b0;
        ch_sel   = '0;
        ch_k     = '0;
        live_max = '0;
        s_max    = '0;
        s_tm     = '0;
        s_tt     = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (addr >= 32'(CH_BASE + c*CH_STRIDE) && addr < 32'(CH_BASE + (c+1)*CH_STRIDE)) begin
                ch_hit   = 1'b1;
                ch_sel   = 32'(c);
                ch_k     = addr - 32'(CH_BASE + c*CH_STRIDE);
                live_max = 32'(max_move[c*MAX_W +: MAX_W]);
                s_max    = 32'(snap_max_q[c]);
                s_tm     = 32'(snap_tm_q[c]);
                s_tt     = 32'(snap_tt_q[c]);
            end
        end
    end

    assign snap_en = rd_en & ch_hit & (ch_k == 32'd0);

    always_comb begin
        rd_byte = 8'hFF;
        if (addr < 32'(CELLS)) begin
            for (int i = 0; i < CELLS; i++)
                if (addr == 32'(i)) rd_byte = 8'(cell_q[i]);
        end else if (addr == 32'(SEED_ADDR)) begin
            rd_byte = seed_q;
        end else if (addr == 32'(CTRL_ADDR)) begin
            rd_byte = {7'b0, run_q};
        end else if (addr == 32'(STAT_ADDR)) begin
            rd_byte = {4'(N_CH), 3'b0, run_q};
        end else if (ch_hit) begin
            // Byte 0 comes from the live value because the snapshot is only taken on this same edge.
            case (ch_k)
                32'd0:   rd_byte = live_max[7:0];
                32'd1:   rd_byte = s_max[15:8];
                32'd2:   rd_byte = s_tm[7:0];
                32'd3:   rd_byte = s_tm[15:8];
                32'd4:   rd_byte = s_tm[23:16];
                32'd5:   rd_byte = s_tm[31:24];
                32'd6:   rd_byte = s_tt[7:0];
                32'd7:   rd_byte = s_tt[15:8];
                32'd8:   rd_byte = s_tt[23:16];
                32'd9:   rd_byte = s_tt[31:24];
                default: rd_byte = 8'hFF;
            endcase
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        seed_d    = seed_q;
        run_d     = run_q;
        clear_d   = 1'b0;
        cell_we   = 1'b0;
        if (rd_en) rd_data_d = rd_byte;
        if (wr_en) begin
            if (addr < 32'(CELLS)) begin
                cell_we = ~run_q;
            end else if (addr == 32'(SEED_ADDR)) begin
                if (!run_q) begin
                    seed_d = bus.int_wr_data;
                    if (bus.int_wr_data == 8'h00) run_d = 1'b0;
                end
            end else if (addr == 32'(CTRL_ADDR)) begin
                run_d   = bus.int_wr_data[0] & (seed_q != 8'h00);
                clear_d = bus.int_wr_data[1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q        <= 1'b0;
            rd_data_q    <= 8'hFF;
            seed_q       <= 8'h00;
            run_q        <= 1'b0;
            clear_q      <= 1'b0;
            engine_rst_q <= 1'b1;
        end else begin
            gnt_q        <= bus.int_req;
            rd_data_q    <= rd_data_d;
            seed_q       <= seed_d;
            run_q        <= run_d;
            clear_q      <= clear_d;
            engine_rst_q <= ~run_q | clear_q;
        end
    end

    // NOTE: the cell and snapshot arrays are reset because software reads them back as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) cell_q[i] <= '0;
            for (int c = 0; c < N_CH; c++) begin
                snap_max_q[c] <= '0;
                snap_tm_q[c]  <= '0;
                snap_tt_q[c]  <= '0;
            end
        end else begin
            for (int i = 0; i < CELLS; i++)
                if (cell_we && addr == 32'(i)) cell_q[i] <= bus.int_wr_data[CELL_W-1:0];
            for (int c = 0; c < N_CH; c++) begin
                if (snap_en && ch_sel == 32'(c)) begin
                    snap_max_q[c] <= max_move[c*MAX_W +: MAX_W];
                    snap_tm_q[c]  <= total_move[c*CNT_W +: CNT_W];
                    snap_tt_q[c]  <= total_trial[c*CNT_W +: CNT_W];
                end
            end
        end
    end

    for (genvar i = 0; i < CELLS; i++) begin : g_board
        assign board[i*CELL_W +: CELL_W] = cell_q[i];
    end

    assign seed            = seed_q;
    assign engine_rst      = engine_rst_q;
    assign bus.int_gnt     = gnt_q;
    assign bus.int_rd_data = rd_data_q;

endmodule

// File: tb/tb_mc_stat_bus_ctrl.sv
// Directed bench for mc_stat_bus_ctrl: grant handshake, register map, run control,
// coherent statistics snapshots and asynchronous reset.
module tb_mc_stat_bus_ctrl;

    localparam int N_CH   = 4;
    localparam int CELLS  = 16;
    localparam int CELL_W = 6;
    localparam int MAX_W  = 16;
    localparam int CNT_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [CELLS*CELL_W-1:0] board;
    logic [7:0]              seed;
    logic                    engine_rst;
    logic [N_CH*MAX_W-1:0]   max_move;
    logic [N_CH*CNT_W-1:0]   total_move;
    logic [N_CH*CNT_W-1:0]   total_trial;

    int checks = 0;
    int errors = 0;

    mc_stat_bus_ctrl_if #(.ADDR_W(16)) bus ();

    mc_stat_bus_ctrl #(.N_CH(N_CH), .CELLS(CELLS), .CELL_W(CELL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .board       (board),
        .seed        (seed),
        .engine_rst  (engine_rst),
        .max_move    (max_move),
        .total_move  (total_move),
        .total_trial (total_trial)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus.int_address = a;
        bus.int_wr_data = d;
        bus.int_write   = 1'b1;
        tick();
        bus.int_write   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        bus.int_address = a;
        bus.int_read    = 1'b1;
        tick();
        bus.int_read    = 1'b0;
        d = bus.int_rd_data;
    endtask

    logic [7:0] rd;

    initial begin
        rst             = 1'b1;
        bus.int_address = '0;
        bus.int_wr_data = '0;
        bus.int_write   = 1'b0;
        bus.int_read    = 1'b0;
        bus.int_req     = 1'b0;
        max_move        = '0;
        total_move      = '0;
        total_trial     = '0;
        repeat (2) tick();

        check("rst_gnt", 32'(bus.int_gnt), 32'd0);
        check("rst_rd_data", 32'(bus.int_rd_data), 32'hFF);
        check("rst_board", 32'(board == '0), 32'd1);
        check("rst_seed", 32'(seed), 32'd0);
        check("rst_engine_rst", 32'(engine_rst), 32'd1);
        rst = 1'b0;
        tick();

        // Strobes without grant are ignored
        bus_write(16'd16, 8'h33);
        check("no_gnt_write", 32'(seed), 32'd0);

        // Grant handshake
        bus.int_req = 1'b1;
        check("gnt_before_edge", 32'(bus.int_gnt), 32'd0);
        tick();
        check("gnt_rise", 32'(bus.int_gnt), 32'd1);
        bus_read(16'd18, rd);
        check("status_idle", 32'(rd), 32'h40);
        bus_read(16'd200, rd);
        check("rd_unmapped_200", 32'(rd), 32'hFF);
        bus.int_req = 1'b0;
        tick();
        check("gnt_fall", 32'(bus.int_gnt), 32'd0);
        bus.int_req = 1'b1;
        tick();
        check("gnt_rise2", 32'(bus.int_gnt), 32'd1);

        // Cells
        bus_write(16'd3, 8'hE5);
        bus_read(16'd3, rd);
        check("cell3_rd", 32'(rd), 32'h25);
        check("cell3_board", 32'(board[23:18]), 32'h25);
        bus_write(16'd15, 8'hFF);
        bus_read(16'd15, rd);
        check("cell15_rd", 32'(rd), 32'h3F);
        bus_read(16'd19, rd);
        check("rd_unmapped_19", 32'(rd), 32'hFF);

        // Run control
        bus_write(16'd16, 8'h07);
        bus_write(16'd17, 8'h01);
        check("run_erst_lag", 32'(engine_rst), 32'd1);
        tick();
        check("run_erst_fall", 32'(engine_rst), 32'd0);
        bus_read(16'd17, rd);
        check("ctrl_run", 32'(rd), 32'h01);
        bus_read(16'd18, rd);
        check("status_run", 32'(rd), 32'h41);
        bus_write(16'd0, 8'h01);
        bus_read(16'd0, rd);
        check("cell0_locked", 32'(rd), 32'h00);
        bus_write(16'd16, 8'h22);
        bus_read(16'd16, rd);
        check("seed_locked", 32'(rd), 32'h07);

        // Coherent snapshots on channel 1
        max_move[16 +: 16]    = 16'hABCD;
        total_move[32 +: 32]  = 32'h11223344;
        total_trial[32 +: 32] = 32'hDEADBEEF;
        bus_read(16'd48, rd);
        check("ch1_k0_live", 32'(rd), 32'hCD);
        max_move    = '0;
        total_move  = '0;
        total_trial = '0;
        bus_read(16'd49, rd); check("ch1_max_b1", 32'(rd), 32'hAB);
        bus_read(16'd50, rd); check("ch1_tm_b0", 32'(rd), 32'h44);
        bus_read(16'd51, rd); check("ch1_tm_b1", 32'(rd), 32'h33);
        bus_read(16'd52, rd); check("ch1_tm_b2", 32'(rd), 32'h22);
        bus_read(16'd53, rd); check("ch1_tm_b3", 32'(rd), 32'h11);
        bus_read(16'd54, rd); check("ch1_tt_b0", 32'(rd), 32'hEF);
        bus_read(16'd57, rd); check("ch1_tt_b3", 32'(rd), 32'hDE);
        bus_read(16'd58, rd); check("ch1_k10", 32'(rd), 32'hFF);
        bus_read(16'd47, rd); check("ch0_k15", 32'(rd), 32'hFF);
        bus_read(16'd33, rd); check("ch0_untouched", 32'(rd), 32'h00);
        bus_read(16'd96, rd); check("ch4_absent", 32'(rd), 32'hFF);

        // Seed zero refuses run; clear pulse
        bus_write(16'd17, 8'h00);
        tick();
        check("stop_erst", 32'(engine_rst), 32'd1);
        bus_write(16'd16, 8'h00);
        bus_write(16'd17, 8'h01);
        bus_read(16'd17, rd);
        check("run_refused", 32'(rd), 32'h00);
        check("run_refused_erst", 32'(engine_rst), 32'd1);
        bus_write(16'd16, 8'h09);
        bus_write(16'd17, 8'h03);
        tick();
        check("start_clear_erst", 32'(engine_rst), 32'd1);
        tick();
        check("start_clear_erst_low", 32'(engine_rst), 32'd0);
        bus_read(16'd17, rd);
        check("ctrl_after_clear", 32'(rd), 32'h01);
        bus_write(16'd17, 8'h03);
        check("pulse_pre", 32'(engine_rst), 32'd0);
        tick();
        check("pulse_high", 32'(engine_rst), 32'd1);
        tick();
        check("pulse_end", 32'(engine_rst), 32'd0);
        bus_read(16'd17, rd);
        check("run_kept", 32'(rd), 32'h01);

        // Simultaneous write and read
        bus_write(16'd17, 8'h00);
        bus_read(16'd18, rd);
        check("status_stopped", 32'(rd), 32'h40);
        bus.int_address = 16'd16;
        bus.int_wr_data = 8'h5A;
        bus.int_write   = 1'b1;
        bus.int_read    = 1'b1;
        tick();
        bus.int_write   = 1'b0;
        bus.int_read    = 1'b0;
        check("wr_rd_seed", 32'(seed), 32'h5A);
        check("wr_rd_hold", 32'(bus.int_rd_data), 32'h40);

        // Asynchronous reset mid-run
        bus_write(16'd17, 8'h01);
        tick();
        check("run_again", 32'(engine_rst), 32'd0);
        #3 rst = 1'b1;
        #1;
        check("arst_erst", 32'(engine_rst), 32'd1);
        check("arst_gnt", 32'(bus.int_gnt), 32'd0);
        check("arst_rd_data", 32'(bus.int_rd_data), 32'hFF);
        check("arst_seed", 32'(seed), 32'd0);
        check("arst_board", 32'(board == '0), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_gnt", 32'(bus.int_gnt), 32'd1);
        bus_read(16'd49, rd);
        check("post_rst_snap", 32'(rd), 32'h00);
        bus_read(16'd17, rd);
        check("post_rst_run", 32'(rd), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
